// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back data cache controller with a 4-word line and a single-line memory port.
// Optional hit/miss counters are built only when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_data_o,
    input  logic [127:0] mem_data_i,
    input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]  hit_cnt_o,
    output logic [15:0]  miss_cnt_o
`endif
);

    localparam int LINES = 2 ** IDX_W;
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t             state_reg;
    logic [LINES-1:0]   valid_reg;
    logic [LINES-1:0]   dirty_reg;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [127:0]       data_mem [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         off;
    logic [TAG_W-1:0]   tag_rd;
    logic [127:0]       line_rd;
    logic [31:0]        line_words [4];
    logic               hit;
    logic               miss;
    logic               refill_done;

    assign idx     = cpu_addr_i[IDX_W+3:4];
    assign tag     = cpu_addr_i[31:IDX_W+4];
    assign off     = cpu_addr_i[3:2];
    assign tag_rd  = tag_mem[idx];
    assign line_rd = data_mem[idx];

    for (genvar gi = 0; gi < 4; gi++) begin : g_words
        assign line_words[gi] = line_rd[gi*32 +: 32];
    end

    // Lookup is only meaningful while idle; during a transfer the pipeline is held anyway.
    assign hit         = (state_reg == IDLE) & cpu_req_i & valid_reg[idx] & (tag_rd == tag);
    assign miss        = (state_reg == IDLE) & cpu_req_i & ~hit;
    assign refill_done = (state_reg == REFILL) & mem_ack_i;
    assign cpu_data_o  = (hit & ~cpu_we_i) ? line_words[off] : 32'd0;
    assign cpu_stall_o = (state_reg != IDLE) | miss;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg  <= IDLE;
            valid_reg  <= '0;
            dirty_reg  <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= 32'd0;
            mem_data_o <= 128'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hit && cpu_we_i) begin
                        dirty_reg[idx] <= 1'b1;
                    end
                    if (miss) begin
                        mem_req_o <= 1'b1;
                        if (valid_reg[idx] && dirty_reg[idx]) begin
                            state_reg  <= WRITEBACK;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= {tag_rd, idx, 4'b0000};
                            mem_data_o <= line_rd;
                        end else begin
                            state_reg  <= REFILL;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {tag, idx, 4'b0000};
                            mem_data_o <= 128'd0;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_reg  <= REFILL;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {tag, idx, 4'b0000};
                        mem_data_o <= 128'd0;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_reg      <= IDLE;
                        mem_req_o      <= 1'b0;
                        mem_addr_o     <= 32'd0;
                        valid_reg[idx] <= 1'b1;
                        dirty_reg[idx] <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays carry no reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (hit && cpu_we_i) begin
                data_mem[idx][{off, 5'b00000} +: 32] <= cpu_data_i;
            end
            if (refill_done) begin
                data_mem[idx] <= mem_data_i;
                tag_mem[idx]  <= tag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic retry_reg;

    // The hit on the retried access right after a refill belongs to the miss already counted.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            retry_reg  <= 1'b0;
            hit_cnt_o  <= 16'd0;
            miss_cnt_o <= 16'd0;
        end else begin
            retry_reg <= refill_done;
            if (hit && !retry_reg && hit_cnt_o != 16'hFFFF) begin
                hit_cnt_o <= hit_cnt_o + 16'd1;
            end
            if (miss && miss_cnt_o != 16'hFFFF) begin
                miss_cnt_o <= miss_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule
